// File: rtl/gun_link_pkg.sv
// Shared frame constants and state encodings for the light-gun serial link.
package gun_link_pkg;

   localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
   localparam int unsigned FRAME_BYTES = 5;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   typedef enum logic [2:0] {HUNT, GOT_SYNC, GOT_B1, GOT_B2, GOT_B3} parse_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 LSB-first byte receiver with a 2-flop input synchronizer.
module uart_rx_byte
   import gun_link_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

   logic            rx_m, rx_s;
   rx_state_t       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      sh_q, sh_d;
   logic            bv_q, bv_d, fe_q, fe_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         bv_q    <= 1'b0;
         fe_q    <= 1'b0;
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         bv_q    <= bv_d;
         fe_q    <= fe_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      sh_d    = sh_q;
      bv_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = START;
         end
         START: begin
            // Mid start bit: a line already back high was only a glitch
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_M1) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == BIT_M1) begin
               cnt_d   = '0;
               state_d = IDLE;
               bv_d    = rx_s;
               fe_d    = !rx_s;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_byte    = sh_q;
   assign byte_valid = bv_q;
   assign frame_err  = fe_q;

endmodule

// File: rtl/gun_link_rx.sv
// Light-gun link receiver: frames, checksums, clamps and edge-detects gun
// coordinate packets before they reach the cursor/shot logic.
module gun_link_rx
   import gun_link_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned GAP_CYCLES   = 21700,
   parameter int unsigned LINK_TIMEOUT = 2500000,
   parameter int unsigned X_MAX        = 319,
   parameter int unsigned Y_MAX        = 479
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       rx,
   output logic [8:0] cursor_x,
   output logic [8:0] cursor_y,
   output logic       shot,
   output logic       link_up,
   output logic [7:0] frame_err_cnt
);

   localparam int unsigned GW = $clog2(GAP_CYCLES + 2);
   localparam int unsigned TW = $clog2(LINK_TIMEOUT + 1);
   localparam logic [8:0] X_LIM = 9'(X_MAX);
   localparam logic [8:0] Y_LIM = 9'(Y_MAX);

   logic [7:0]   rx_byte;
   logic         byte_valid, rx_ferr;
   parse_state_t pstate_q, pstate_d;
   logic [7:0]   b1_q, b2_q, b3_q;
   logic [GW-1:0] gap_q;
   logic [TW-1:0] timer_q;
   logic         trig_hist_q;
   logic         commit, reject, gap_exp, xor_ok;
   logic [8:0]   x_raw, y_raw;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .rx         (rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (rx_ferr)
   );

   assign xor_ok  = (rx_byte == (b1_q ^ b2_q ^ b3_q));
   assign gap_exp = (gap_q >= GW'(GAP_CYCLES)) && !byte_valid;
   assign x_raw   = {b1_q[0], b2_q};
   assign y_raw   = {b1_q[1], b3_q};

   always_comb begin
      pstate_d = pstate_q;
      commit   = 1'b0;
      reject   = 1'b0;
      if (pstate_q != HUNT && (rx_ferr || gap_exp)) begin
         reject   = 1'b1;
         pstate_d = HUNT;
      end else if (byte_valid) begin
         case (pstate_q)
            HUNT:     if (rx_byte == SYNC_BYTE) pstate_d = GOT_SYNC;
            GOT_SYNC: begin
               if (rx_byte[6:2] != '0) begin
                  reject   = 1'b1;
                  pstate_d = HUNT;
               end else begin
                  pstate_d = GOT_B1;
               end
            end
            GOT_B1:   pstate_d = GOT_B2;
            GOT_B2:   pstate_d = GOT_B3;
            GOT_B3: begin
               pstate_d = HUNT;
               commit   = xor_ok;
               reject   = !xor_ok;
            end
            default:  pstate_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pstate_q      <= HUNT;
         b1_q          <= '0;
         b2_q          <= '0;
         b3_q          <= '0;
         gap_q         <= '0;
         timer_q       <= '0;
         trig_hist_q   <= 1'b0;
         cursor_x      <= '0;
         cursor_y      <= '0;
         shot          <= 1'b0;
         link_up       <= 1'b0;
         frame_err_cnt <= '0;
      end else begin
         pstate_q <= pstate_d;
         if (byte_valid) begin
            case (pstate_q)
               GOT_SYNC: b1_q <= rx_byte;
               GOT_B1:   b2_q <= rx_byte;
               GOT_B2:   b3_q <= rx_byte;
               default:  ;
            endcase
         end
         // Gap is measured from the last accepted byte; it restarts with every byte
         if (pstate_q == HUNT || byte_valid) gap_q <= '0;
         else                                gap_q <= gap_q + GW'(1);

         if (reject && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;

         shot <= commit && b1_q[7] && !trig_hist_q;
         if (commit) begin
            cursor_x    <= (x_raw > X_LIM) ? X_LIM : x_raw;
            cursor_y    <= (y_raw > Y_LIM) ? Y_LIM : y_raw;
            trig_hist_q <= b1_q[7];
            timer_q     <= TW'(LINK_TIMEOUT);
            link_up     <= 1'b1;
         end else if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
            if (timer_q == TW'(1)) begin
               link_up     <= 1'b0;
               trig_hist_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_gun_link_rx.sv
// Directed bench for gun_link_rx: frame vectors plus gap, stop-bit, timeout,
// reset and glitch sequences.
module tb_gun_link_rx;

   localparam int unsigned CPB = 8;
   localparam int unsigned GAP = 200;
   localparam int unsigned LTO = 2000;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       rx = 1'b1;
   logic [8:0] cursor_x, cursor_y;
   logic       shot, link_up;
   logic [7:0] frame_err_cnt;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned shot_cnt = 0;
   int unsigned bv_cnt = 0;

   always #5 Clk = ~Clk;

   gun_link_rx #(
      .CLKS_PER_BIT (CPB),
      .GAP_CYCLES   (GAP),
      .LINK_TIMEOUT (LTO),
      .X_MAX        (319),
      .Y_MAX        (479)
   ) dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .rx            (rx),
      .cursor_x      (cursor_x),
      .cursor_y      (cursor_y),
      .shot          (shot),
      .link_up       (link_up),
      .frame_err_cnt (frame_err_cnt)
   );

   always @(negedge Clk) begin
      if (shot) shot_cnt++;
      if (dut.u_rx.byte_valid) bv_cnt++;
   end

   typedef struct {
      logic [4:0][7:0] f;
      int unsigned     x, y, shots, link, err;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CPB) @(negedge Clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge Clk);
      end
      rx = stop;
      repeat (CPB) @(negedge Clk);
      rx = 1'b1;
   endtask

   task automatic send_frame(input logic [4:0][7:0] f);
      for (int i = 4; i >= 0; i--) send_byte(f[i], 1'b1);
      repeat (5) @(negedge Clk);
   endtask

   task automatic chk_outs(input string tag, input int unsigned x, input int unsigned y,
                           input int unsigned link, input int unsigned err);
      chk({tag, ".x"},    32'(cursor_x), x);
      chk({tag, ".y"},    32'(cursor_y), y);
      chk({tag, ".link"}, 32'(link_up), link);
      chk({tag, ".err"},  32'(frame_err_cnt), err);
   endtask

   initial begin
      int unsigned s0;
      logic [7:0] partial;

      // checksum byte is B1^B2^B3
      tbl[0] = '{f: {8'hA5, 8'h01, 8'h2C, 8'h10, 8'h3D}, x: 300, y: 16,  shots: 0, link: 1, err: 0};
      tbl[1] = '{f: {8'hA5, 8'h83, 8'hF0, 8'hF0, 8'h83}, x: 319, y: 479, shots: 1, link: 1, err: 0};
      tbl[2] = '{f: {8'hA5, 8'h83, 8'hF0, 8'hF0, 8'h83}, x: 319, y: 479, shots: 0, link: 1, err: 0};
      tbl[3] = '{f: {8'hA5, 8'h01, 8'h2C, 8'h10, 8'h3C}, x: 319, y: 479, shots: 0, link: 1, err: 1};
      tbl[4] = '{f: {8'hA5, 8'h01, 8'h2C, 8'h10, 8'h3D}, x: 300, y: 16,  shots: 0, link: 1, err: 1};
      tbl[5] = '{f: {8'hA5, 8'h83, 8'h05, 8'h07, 8'h81}, x: 261, y: 263, shots: 1, link: 1, err: 1};

      repeat (4) @(negedge Clk);
      chk("rst.shot", 32'(shot), 0);
      chk_outs("rst", 0, 0, 0, 0);
      Reset_n = 1'b1;
      repeat (10) @(negedge Clk);

      for (int i = 0; i < 6; i++) begin
         s0 = shot_cnt;
         send_frame(tbl[i].f);
         chk($sformatf("v%0d.shot", i), shot_cnt - s0, tbl[i].shots);
         chk_outs($sformatf("v%0d", i), tbl[i].x, tbl[i].y, tbl[i].link, tbl[i].err);
         repeat (20) @(negedge Clk);
      end

      // Inter-byte gap abort, then a full frame still commits
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      repeat (300) @(negedge Clk);
      s0 = shot_cnt;
      send_frame(tbl[0].f);
      chk("gap.shot", shot_cnt - s0, 0);
      chk_outs("gap", 300, 16, 1, 2);
      repeat (20) @(negedge Clk);

      // Bad stop bit mid-frame: remaining bytes are ignored in HUNT
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h2C, 1'b0);
      send_byte(8'h10, 1'b1);
      send_byte(8'h3D, 1'b1);
      repeat (5) @(negedge Clk);
      chk_outs("stoperr", 300, 16, 1, 3);
      send_byte(8'h55, 1'b0);
      repeat (20) @(negedge Clk);
      chk("hunt_ferr.err", 32'(frame_err_cnt), 3);
      send_frame({8'hA5, 8'h00, 8'h0A, 8'h14, 8'h1E});
      chk_outs("after_err", 10, 20, 1, 3);
      repeat (20) @(negedge Clk);

      // Link timeout clears trigger history
      s0 = shot_cnt;
      send_frame(tbl[5].f);
      chk("to_pre.shot", shot_cnt - s0, 1);
      repeat (2100) @(negedge Clk);
      chk_outs("timeout", 261, 263, 0, 3);
      s0 = shot_cnt;
      send_frame(tbl[5].f);
      chk("to_post.shot", shot_cnt - s0, 1);
      chk("to_post.link", 32'(link_up), 1);
      repeat (20) @(negedge Clk);

      // Reset in the middle of B2
      send_byte(8'hA5, 1'b1);
      send_byte(8'h83, 1'b1);
      partial = 8'h05;
      rx = 1'b0;
      repeat (CPB) @(negedge Clk);
      for (int i = 0; i < 3; i++) begin
         rx = partial[i];
         repeat (CPB) @(negedge Clk);
      end
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      rx = 1'b1;
      chk("midrst.shot", 32'(shot), 0);
      chk_outs("midrst", 0, 0, 0, 0);
      repeat (100) @(negedge Clk);
      chk_outs("midrst_idle", 0, 0, 0, 0);
      s0 = shot_cnt;
      send_frame(tbl[5].f);
      chk("postrst.shot", shot_cnt - s0, 1);
      chk_outs("postrst", 261, 263, 1, 0);
      repeat (20) @(negedge Clk);

      // Quarter-bit low glitch in IDLE
      s0 = bv_cnt;
      rx = 1'b0;
      repeat (CPB / 4) @(negedge Clk);
      rx = 1'b1;
      repeat (60) @(negedge Clk);
      chk("glitch.bv", bv_cnt - s0, 0);
      chk_outs("glitch", 261, 263, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
